hd44780_feeder: RTL and testbench



---
 rtl/hd44780_pkg.sv | 22 ++
 rtl/hd44780_fifo.sv | 53 +++++
 rtl/hd44780_feeder.sv | 119 +++++++++++
 tb/tb_hd44780_feeder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 feeder: FSM encoding, FIFO entry layout and defaults.
package hd44780_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;

  localparam int ENTRY_W            = 9;
  localparam int ENTRY_RS_BIT       = 8;
  localparam int ENTRY_DATA_MSB     = 7;
  localparam int ENTRY_DATA_LSB     = 0;
  localparam int DEFAULT_DEPTH_BITS = 4;
  localparam int DEFAULT_BUSY_WAIT  = 4;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic rs, input logic [7:0] data);
    return {rs, data};
  endfunction

endpackage

// File: rtl/hd44780_fifo.sv
// Synchronous FIFO of {rs, byte} LCD writes; full/empty are decided on the count at the start of the cycle.
module hd44780_fifo
  import hd44780_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ENTRY_W-1:0]    push_entry,
  input  logic                  pop,
  output logic [ENTRY_W-1:0]    head,
  output logic                  push_accepted,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic                  pop_ok;

  assign full          = (count == (DEPTH_BITS+1)'(DEPTH));
  assign empty         = (count == '0);
  assign push_accepted = push && !full;
  assign pop_ok        = pop && !empty;
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accepted) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)        rd_ptr <= rd_ptr + 1'b1;
      case ({push_accepted, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_accepted) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/hd44780_feeder.sv
// Buffers LCD writes and drains them one at a time into hd44780_controller, pacing on its busy flag.
module hd44780_feeder
  import hd44780_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS,
  parameter int BUSY_WAIT  = DEFAULT_BUSY_WAIT
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  STB_I,
  input  logic                  i_rs,
  input  logic [7:0]            i_dat,
  output logic                  o_ack,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_BITS:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_idle,
  output logic                  o_lcd_stb,
  output logic                  o_lcd_rs,
  output logic [7:0]            o_lcd_data,
  input  logic                  i_lcd_busy
);

  localparam int TIMER_W = $clog2(BUSY_WAIT + 1);

  feeder_state_e        state;
  feeder_state_e        state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [ENTRY_W-1:0]   head;
  logic                 push_accepted;
  logic                 pop;
  logic                 timer_load;
  logic                 timer_dec;
  logic                 issue;

  hd44780_fifo #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk           (CLK_I),
    .rst           (RST_I),
    .push          (STB_I),
    .push_entry    (pack_entry(i_rs, i_dat)),
    .pop           (pop),
    .head          (head),
    .push_accepted (push_accepted),
    .full          (o_full),
    .empty         (o_empty),
    .count         (o_count)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_nxt;
  end

  // A strobe the controller never answers times out back to IDLE; the entry is not retried.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!o_empty && !i_lcd_busy) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (i_lcd_busy)                 state_nxt = WAIT_DONE;
        else if (timer <= TIMER_W'(1))  state_nxt = IDLE;
      end
      WAIT_DONE: if (!i_lcd_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    issue      = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE:      pop = !o_empty && !i_lcd_busy;
      ISSUE:     begin
        issue      = 1'b1;
        timer_load = 1'b1;
      end
      WAIT_BUSY: timer_dec = !i_lcd_busy;
      default:   ;
    endcase
  end

  assign o_lcd_stb = issue;

  always_ff @(posedge CLK_I) begin
    if (RST_I)           timer <= '0;
    else if (timer_load) timer <= TIMER_W'(BUSY_WAIT);
    else if (timer_dec)  timer <= timer - 1'b1;
  end

  // The popped entry stays on the controller inputs until the next pop.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= '0;
    end else if (pop) begin
      o_lcd_rs   <= head[ENTRY_RS_BIT];
      o_lcd_data <= head[ENTRY_DATA_MSB:ENTRY_DATA_LSB];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      o_ack      <= 1'b0;
      o_overflow <= 1'b0;
      o_idle     <= 1'b0;
    end else begin
      o_ack  <= push_accepted;
      o_idle <= o_empty && (state == IDLE) && !i_lcd_busy;
      if (STB_I && o_full) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hd44780_feeder.sv
// Directed bench for hd44780_feeder with a hand-driven model of the controller busy flag.
module tb_hd44780_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb;
  logic       rs;
  logic [7:0] dat;
  logic       busy;
  logic       o_ack, o_full, o_empty, o_overflow, o_idle;
  logic       o_lcd_stb, o_lcd_rs;
  logic [7:0] o_lcd_data;
  logic [4:0] o_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hd44780_feeder #(.DEPTH_BITS(4), .BUSY_WAIT(4)) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .STB_I      (stb),
    .i_rs       (rs),
    .i_dat      (dat),
    .o_ack      (o_ack),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_idle     (o_idle),
    .o_lcd_stb  (o_lcd_stb),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_data (o_lcd_data),
    .i_lcd_busy (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_stb(input string tag, input int max);
    int n = 0;
    while (!o_lcd_stb && n < max) begin
      step();
      n++;
    end
    chk({tag, " strobe seen"}, 32'(o_lcd_stb), 32'd1);
  endtask

  task automatic hold_busy(input string tag, input int n, input logic exp_rs, input logic [7:0] exp_d);
    int strobes = 0;
    int moved = 0;
    busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (o_lcd_stb) strobes++;
      if (o_lcd_rs !== exp_rs || o_lcd_data !== exp_d) moved++;
    end
    busy = 1'b0;
    chk({tag, " strobes during busy"}, 32'(strobes), 32'd0);
    chk({tag, " rs/data held"}, 32'(moved), 32'd0);
  endtask

  task automatic serve(input string tag, input logic exp_rs, input logic [7:0] exp_d, input int busy_n);
    wait_stb(tag, 60);
    chk({tag, " rs"}, 32'(o_lcd_rs), 32'(exp_rs));
    chk({tag, " data"}, 32'(o_lcd_data), 32'(exp_d));
    hold_busy(tag, busy_n, exp_rs, exp_d);
  endtask

  task automatic quiet(input string tag, input int n);
    int strobes = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (o_lcd_stb) strobes++;
    end
    chk({tag, " no strobe"}, 32'(strobes), 32'd0);
  endtask

  initial begin
    int acks;
    int strobes;
    rst  = 1'b1;
    stb  = 1'b0;
    rs   = 1'b0;
    dat  = 8'h00;
    busy = 1'b0;

    // Reset values
    do_reset();
    chk("rst ack", 32'(o_ack), 32'd0);
    chk("rst full", 32'(o_full), 32'd0);
    chk("rst empty", 32'(o_empty), 32'd1);
    chk("rst count", 32'(o_count), 32'd0);
    chk("rst overflow", 32'(o_overflow), 32'd0);
    chk("rst idle", 32'(o_idle), 32'd0);
    chk("rst stb", 32'(o_lcd_stb), 32'd0);
    chk("rst rs", 32'(o_lcd_rs), 32'd0);
    chk("rst data", 32'(o_lcd_data), 32'd0);

    // Single push: ack at N+1, strobe in the following cycle
    stb = 1'b1; rs = 1'b1; dat = 8'h6D;
    step();
    stb = 1'b0;
    chk("t1 ack", 32'(o_ack), 32'd1);
    chk("t1 stb early", 32'(o_lcd_stb), 32'd0);
    chk("t1 count", 32'(o_count), 32'd1);
    step();
    chk("t1 stb", 32'(o_lcd_stb), 32'd1);
    chk("t1 rs", 32'(o_lcd_rs), 32'd1);
    chk("t1 data", 32'(o_lcd_data), 32'h6D);
    chk("t1 ack gone", 32'(o_ack), 32'd0);
    chk("t1 popped", 32'(o_count), 32'd0);
    hold_busy("t1", 20, 1'b1, 8'h6D);
    step(); step(); step();
    chk("t1 idle", 32'(o_idle), 32'd1);

    // Back-to-back pushes, each strobe answered by 20 busy cycles
    stb = 1'b1; rs = 1'b1; dat = 8'h6D;
    step();
    chk("t2 ack0", 32'(o_ack), 32'd1);
    rs = 1'b0; dat = 8'h8E;
    step();
    stb = 1'b0;
    chk("t2 ack1", 32'(o_ack), 32'd1);
    serve("t2a", 1'b1, 8'h6D, 20);
    serve("t2b", 1'b0, 8'h8E, 20);
    step(); step(); step();
    chk("t2 idle", 32'(o_idle), 32'd1);

    // Busy high from reset holds off issue while pushes accumulate
    busy = 1'b1;
    do_reset();
    stb = 1'b1;
    rs = 1'b0; dat = 8'hA1; step();
    rs = 1'b1; dat = 8'hB2; step();
    rs = 1'b0; dat = 8'hC3; step();
    stb = 1'b0;
    chk("t3 count3", 32'(o_count), 32'd3);
    strobes = 0;
    for (int i = 0; i < 97; i++) begin
      step();
      if (o_lcd_stb) strobes++;
    end
    chk("t3 held off", 32'(strobes), 32'd0);
    chk("t3 idle while busy", 32'(o_idle), 32'd0);
    busy = 1'b0;
    wait_stb("t3a", 20);
    chk("t3a data", 32'(o_lcd_data), 32'hA1);
    chk("t3 count2", 32'(o_count), 32'd2);
    hold_busy("t3a", 5, 1'b0, 8'hA1);
    serve("t3b", 1'b1, 8'hB2, 5);
    serve("t3c", 1'b0, 8'hC3, 5);
    chk("t3 count0", 32'(o_count), 32'd0);

    // Overfill: 17 pushes into 16 entries while busy
    busy = 1'b1;
    do_reset();
    acks = 0;
    stb = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rs  = i[0];
      dat = 8'(i);
      step();
      if (o_ack) acks++;
    end
    stb = 1'b0;
    step();
    if (o_ack) acks++;
    chk("t4 acks", 32'(acks), 32'd16);
    chk("t4 full", 32'(o_full), 32'd1);
    chk("t4 overflow", 32'(o_overflow), 32'd1);
    chk("t4 count", 32'(o_count), 32'd16);
    busy = 1'b0;
    for (int i = 0; i < 16; i++) serve("t4 drain", i[0], 8'(i), 2);
    quiet("t4 17th", 30);
    chk("t4 empty", 32'(o_empty), 32'd1);
    chk("t4 overflow sticky", 32'(o_overflow), 32'd1);

    // Busy never rises: timeout returns to IDLE BUSY_WAIT+1 cycles after the strobe
    busy = 1'b0;
    do_reset();
    stb = 1'b1; rs = 1'b0; dat = 8'h11;
    step();
    dat = 8'h22;
    step();
    stb = 1'b0;
    chk("t5 stb0", 32'(o_lcd_stb), 32'd1);
    chk("t5 data0", 32'(o_lcd_data), 32'h11);
    quiet("t5 gap", 5);
    step();
    chk("t5 stb1", 32'(o_lcd_stb), 32'd1);
    chk("t5 data1", 32'(o_lcd_data), 32'h22);
    step(); step(); step(); step(); step();
    chk("t5 idle not yet", 32'(o_idle), 32'd0);
    step();
    chk("t5 idle", 32'(o_idle), 32'd1);

    // Reset in WAIT_DONE with 5 entries queued
    busy = 1'b1;
    do_reset();
    stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rs  = 1'b1;
      dat = 8'(8'h30 + i);
      step();
    end
    stb = 1'b0;
    busy = 1'b0;
    wait_stb("t6", 20);
    chk("t6 data", 32'(o_lcd_data), 32'h30);
    busy = 1'b1;
    step(); step();
    chk("t6 count5", 32'(o_count), 32'd5);
    rst = 1'b1;
    step();
    chk("t6 count", 32'(o_count), 32'd0);
    chk("t6 empty", 32'(o_empty), 32'd1);
    chk("t6 stb", 32'(o_lcd_stb), 32'd0);
    chk("t6 overflow", 32'(o_overflow), 32'd0);
    rst = 1'b0;
    busy = 1'b0;
    quiet("t6 after reset", 20);
    chk("t6 still empty", 32'(o_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
